// File: rtl/alu.sv
// 32-bit integer ALU for the single-cycle MIPS datapath.
// Combinational result/zero/overflow for same-cycle branch resolution,
// plus a registered copy of all three for debug and pipelined consumers.
// A single adder serves ADD, SUB, SLT and SLTS. A single right barrel
// shifter serves SRL, SRA and SLL: for SLL the data is bit-reversed on
// the way in and on the way out.
module alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       alucont,
  input  logic [WIDTH-1:0] rd1,
  input  logic [WIDTH-1:0] rd2,
  output logic [WIDTH-1:0] res,
  output logic             zero,
  output logic             ovf,
  output logic [WIDTH-1:0] res_q,
  output logic             zero_q,
  output logic             ovf_q
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTS = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_NOR  = 4'b1100;

  // ---------------------------------------------------------------
  // Shared adder: subtraction and both compares use rd1 + ~rd2 + 1.
  // ---------------------------------------------------------------
  logic             use_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   add_full;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             ovf_raw;
  logic             lt_unsigned;
  logic             lt_signed;

  assign use_sub   = (alucont == OP_SUB) || (alucont == OP_SLT) ||
                     (alucont == OP_SLTS);
  assign b_eff     = use_sub ? ~rd2 : rd2;
  assign add_full  = {1'b0, rd1} + {1'b0, b_eff} + {{WIDTH{1'b0}}, use_sub};
  assign sum       = add_full[WIDTH-1:0];
  assign carry_out = add_full[WIDTH];

  // Signed overflow: both effective operands agree in sign and the sum
  // disagrees. With b inverted for SUB this is exactly "operand signs
  // differ and result sign differs from rd1".
  assign ovf_raw     = (rd1[MSB] == b_eff[MSB]) && (sum[MSB] != rd1[MSB]);

  // No borrow out of rd1 - rd2 means rd1 >= rd2 unsigned.
  assign lt_unsigned = ~carry_out;
  // Signed less-than is the difference sign, corrected when it overflowed.
  assign lt_signed   = sum[MSB] ^ ovf_raw;

  // ---------------------------------------------------------------
  // Barrel shifter (right-shifting core, reversal for left shifts).
  // ---------------------------------------------------------------
  logic             shift_left;
  logic             shift_fill;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] rd2_rev;
  logic [WIDTH-1:0] shift_in;
  logic [WIDTH-1:0] shift_out;
  logic [WIDTH-1:0] shift_out_rev;
  logic [WIDTH-1:0] stage [0:SHW];

  assign shift_left = (alucont == OP_SLL);
  // Only SRA fills with the sign bit; SLL/SRL fill with zeros.
  assign shift_fill = (alucont == OP_SRA) ? rd2[MSB] : 1'b0;
  // Only the low bits of rd1 select the amount; the rest is ignored.
  assign shamt      = rd1[SHW-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_rev
      assign rd2_rev[gi]       = rd2[MSB - gi];
      assign shift_out_rev[gi] = shift_out[MSB - gi];
    end
  endgenerate

  assign shift_in = shift_left ? rd2_rev : rd2;
  assign stage[0] = shift_in;

  // Stage gi shifts right by 2**gi when shamt[gi] is set.
  generate
    for (gi = 0; gi < SHW; gi++) begin : g_shift
      localparam int STEP = 1 << gi;
      assign stage[gi+1] = shamt[gi] ?
                           {{STEP{shift_fill}}, stage[gi][WIDTH-1:STEP]} :
                           stage[gi];
    end
  endgenerate

  assign shift_out = stage[SHW];

  // ---------------------------------------------------------------
  // Result select; undefined codes produce zero, never X.
  // ---------------------------------------------------------------
  // Combinational result mux over all opcode units.
  always_comb begin
    res = '0;
    case (alucont)
      OP_AND:  res = rd1 & rd2;
      OP_OR:   res = rd1 | rd2;
      OP_ADD:  res = sum;
      OP_XOR:  res = rd1 ^ rd2;
      OP_SLL:  res = shift_out_rev;
      OP_SRL:  res = shift_out;
      OP_SUB:  res = sum;
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, lt_unsigned};
      OP_SLTS: res = {{(WIDTH-1){1'b0}}, lt_signed};
      OP_SRA:  res = shift_out;
      OP_NOR:  res = ~(rd1 | rd2);
      default: res = '0;
    endcase
  end

  assign zero = ~|res;
  // Overflow is reported only for the arithmetic ops; the compares reuse
  // the subtractor but never flag it.
  assign ovf  = ((alucont == OP_ADD) || (alucont == OP_SUB)) ? ovf_raw : 1'b0;

  // ---------------------------------------------------------------
  // Registered copy, one cycle behind; reset shows a zero result.
  // ---------------------------------------------------------------
  // Capture result and flags each cycle; async reset clears at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q  <= '0;
      zero_q <= 1'b1;
      ovf_q  <= 1'b0;
    end else begin
      res_q  <= res;
      zero_q <= zero;
      ovf_q  <= ovf;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu: hand-computed vectors for every
// opcode class, flag boundaries, and the registered/reset behaviour.
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [3:0]  alucont;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] res;
  logic        zero;
  logic        ovf;
  logic [31:0] res_q;
  logic        zero_q;
  logic        ovf_q;

  int checks_cnt;
  int errors_cnt;

  alu #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .alucont (alucont),
    .rd1     (rd1),
    .rd2     (rd2),
    .res     (res),
    .zero    (zero),
    .ovf     (ovf),
    .res_q   (res_q),
    .zero_q  (zero_q),
    .ovf_q   (ovf_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  // Apply one combinational vector and check result and both flags.
  task automatic vec(input string tag, input logic [3:0] op,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp_res, input logic exp_zero,
                     input logic exp_ovf);
    alucont = op;
    rd1     = a;
    rd2     = b;
    #1;
    check({tag, ".res"},  res,          exp_res);
    check({tag, ".zero"}, {31'd0, zero}, {31'd0, exp_zero});
    check({tag, ".ovf"},  {31'd0, ovf},  {31'd0, exp_ovf});
  endtask

  initial begin
    checks_cnt = 0;
    errors_cnt = 0;
    rst_n   = 1'b0;
    alucont = 4'b0010;
    rd1     = 32'd9;
    rd2     = 32'd9;

    // Reset held: registers show the reset state despite clocks running.
    repeat (2) @(posedge clk);
    #1;
    check("rst.res_q",  res_q,           32'd0);
    check("rst.zero_q", {31'd0, zero_q}, 32'd1);
    check("rst.ovf_q",  {31'd0, ovf_q},  32'd0);
    // Combinational path is independent of reset.
    check("rst.comb_res", res, 32'd18);

    @(negedge clk);
    rst_n = 1'b1;

    // Logic ops
    vec("and", 4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1'b0);
    vec("or",  4'b0001, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFFF0_FF34, 1'b0, 1'b0);
    vec("nor", 4'b1100, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h000F_00CB, 1'b0, 1'b0);
    vec("xor", 4'b0011, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFF00_ED34, 1'b0, 1'b0);

    // Arithmetic and overflow boundaries
    vec("add_ovf",  4'b0010, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b1);
    vec("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000, 1'b1, 1'b0);
    vec("sub_neg",  4'b0110, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);
    vec("sub_ovf",  4'b0110, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1);
    vec("sub_zero", 4'b0110, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'd0, 1'b1, 1'b0);

    // Compares (overflow never flagged)
    vec("slt_u",  4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0);
    vec("slts_s", 4'b1000, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0);
    vec("slt_3_9",  4'b0111, 32'd3, 32'd9, 32'd1, 1'b0, 1'b0);
    vec("slts_3_9", 4'b1000, 32'd3, 32'd9, 32'd1, 1'b0, 1'b0);
    vec("slts_ovf", 4'b1000, 32'h8000_0000, 32'd1, 32'd1, 1'b0, 1'b0);

    // Shifts, including amount extremes and ignored upper rd1 bits
    vec("sll", 4'b0100, 32'd4, 32'h8000_00F0, 32'h0000_0F00, 1'b0, 1'b0);
    vec("srl", 4'b0101, 32'd4, 32'h8000_00F0, 32'h0800_000F, 1'b0, 1'b0);
    vec("sra", 4'b1001, 32'd4, 32'h8000_00F0, 32'hF800_000F, 1'b0, 1'b0);
    vec("sra_hi", 4'b1001, 32'hFFFF_FFE4, 32'h8000_00F0, 32'hF800_000F, 1'b0, 1'b0);
    vec("sra_31", 4'b1001, 32'd31, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    vec("sll_0",  4'b0100, 32'd0, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0);
    vec("srl_31", 4'b0101, 32'd31, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0);

    // Undefined opcodes give zero result, zero flag set
    vec("undef_f", 4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0);
    vec("undef_a", 4'b1010, 32'h1234_5678, 32'h0000_0001, 32'd0, 1'b1, 1'b0);

    // Registered path: one cycle latency
    @(negedge clk);
    alucont = 4'b0010;
    rd1     = 32'd2;
    rd2     = 32'd3;
    @(posedge clk);
    #1;
    check("reg.res_q",  res_q,           32'd5);
    check("reg.zero_q", {31'd0, zero_q}, 32'd0);
    // Input change between edges must not reach the register early.
    rd1 = 32'h7FFF_FFFF;
    rd2 = 32'd1;
    #1;
    check("reg.hold", res_q, 32'd5);
    @(posedge clk);
    #1;
    check("reg.ovf_q",  {31'd0, ovf_q}, 32'd1);
    check("reg.res_q2", res_q,          32'h8000_0000);

    // Async reset between edges clears at once, comb path untouched.
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.res_q",  res_q,           32'd0);
    check("arst.zero_q", {31'd0, zero_q}, 32'd1);
    check("arst.ovf_q",  {31'd0, ovf_q},  32'd0);
    check("arst.comb",   res,             32'h8000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
